// File: rtl/mux2_rr_sel.sv
// Round-robin packet arbiter that drives the select of an external 2:1 mux.
// Define MUX2_RR_STATS_EN to add per-input beat counters (beats0/beats1/stats_clr).
module mux2_rr_sel #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_valid,
  input  logic [1:0]       in_last,
  output logic [1:0]       in_ready,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef MUX2_RR_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] beats0,
  output logic [CNT_W-1:0] beats1
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;
  logic   g, g_nxt;
  logic   prio, prio_nxt;
  logic   xfer;

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("mux2_rr_sel: CNT_W must be nonzero");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g     <= 1'b0;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      prio  <= prio_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    prio_nxt  = prio;
    case (state)
      IDLE: begin
        if (|in_valid) begin
          state_nxt = BUSY;
          g_nxt     = (in_valid == 2'b11) ? prio : in_valid[1];
        end
      end
      BUSY: begin
        if (xfer && out_last) begin
          prio_nxt = ~g;
          if (in_valid[~g]) g_nxt = ~g;
          else              state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake is masked during reset so a packet abandoned by reset never completes a beat.
  always_comb begin
    in_ready    = '0;
    out_valid   = (state == BUSY) && in_valid[g] && !rst;
    out_last    = out_valid && in_last[g];
    in_ready[g] = (state == BUSY) && out_ready && !rst;
    xfer        = out_valid && out_ready;
  end

  assign sel = g;

`ifdef MUX2_RR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      beats0 <= '0;
      beats1 <= '0;
    end else if (xfer) begin
      if (g) beats1 <= beats1 + 1'b1;
      else   beats0 <= beats0 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux2_rr_sel.sv
// Self-checking bench for mux2_rr_sel: directed vector table, random run against a
// packet-level reference model, and beat-counter checks when MUX2_RR_STATS_EN is set.
module tb_mux2_rr_sel;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_valid, in_last, in_ready;
  logic       sel, out_valid, out_ready, out_last;
`ifdef MUX2_RR_STATS_EN
  logic       stats_clr;
  logic [3:0] beats0, beats1;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  mux2_rr_sel #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef MUX2_RR_STATS_EN
    ,
    .stats_clr (stats_clr),
    .beats0    (beats0),
    .beats1    (beats1)
`endif
  );

  typedef struct {
    logic       rst;
    logic [1:0] iv;
    logic [1:0] il;
    logic       ordy;
    logic       sel;
    logic       ov;
    logic [1:0] ir;
    logic       ol;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [4:0] outs();
    return {sel, out_valid, in_ready, out_last};
  endfunction

  // Packet-level reference: who owns the mux, who wins the next tie, where sel rests.
  int   owner;     // -1 when no packet is open
  int   tie_win;
  int   rest_sel;

  function automatic logic [4:0] model_out(input logic r, input logic [1:0] iv,
                                           input logic [1:0] il, input logic ordy);
    logic       s, ov, ol;
    logic [1:0] ir;
    s  = (owner >= 0) ? owner[0] : rest_sel[0];
    ov = !r && owner >= 0 && iv[owner];
    ol = ov && il[owner];
    ir = (!r && owner >= 0 && ordy) ? (2'b01 << owner) : 2'b00;
    return {s, ov, ir, ol};
  endfunction

  task automatic model_step(input logic r, input logic [1:0] iv,
                            input logic [1:0] il, input logic ordy);
    if (r) begin
      owner = -1; tie_win = 0; rest_sel = 0;
    end else if (owner < 0) begin
      if (iv != 2'b00) begin
        if (iv == 2'b11)      owner = tie_win;
        else if (iv == 2'b10) owner = 1;
        else                  owner = 0;
        rest_sel = owner;
      end
    end else if (iv[owner] && ordy && il[owner]) begin
      tie_win = 1 - owner;
      if (iv[1 - owner]) begin
        owner = 1 - owner;
        rest_sel = owner;
      end else begin
        owner = -1;
      end
    end
  endtask

`ifdef MUX2_RR_STATS_EN
  task automatic pkt(input int s, input int n);
    in_valid  = 2'b01 << s;
    in_last   = 2'b00;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < n; b++) begin
      in_last = (b == n - 1) ? in_valid : 2'b00;
      @(posedge clk); #1;
    end
    in_valid = 2'b00;
    in_last  = 2'b00;
  endtask
`endif

  vec_t vecs [37];

  initial begin
    //           rst   iv     il     rdy   sel   ov    ir     ol
    vecs = '{
      '{1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0},  // reset held, both valid
      '{1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0},
      '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0},  // arbitration cycle
      '{1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0},  // D0 granted, stalled
      '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0},  // contention: D0 3 beats
      '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0},
      '{1'b0, 2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1},
      '{1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0},  // D1 3 beats, no bubble
      '{1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0},
      '{1'b0, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1},
      '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0},  // D0 again
      '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0},
      '{1'b0, 2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1},
      '{1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0},  // D1 owns, no data
      '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1},
      '{1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0},  // idle, sel rests at 1
      '{1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0},  // backpressure: D1 2 beats
      '{1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0},
      '{1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0},
      '{1'b0, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1},
      '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1},
      '{1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0},  // back in idle
      '{1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0},  // bubble: D0 request
      '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0},
      '{1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0},  // D0 drops, D1 waits
      '{1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0},
      '{1'b0, 2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1},
      '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1},  // D1 only after D0 last
      '{1'b0, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0},  // lone D0 1-beat packets
      '{1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1},
      '{1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0},  // idle gap
      '{1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1},
      '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0},  // tie goes to D1
      '{1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1},
      '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0},  // D0 owns mid-packet
      '{1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0},  // reset abandons packet
      '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0}
    };

    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b0;
`ifdef MUX2_RR_STATS_EN
    stats_clr = 1'b0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;

    for (int i = 0; i < 37; i++) begin
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_last = vecs[i].il; out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("vec%0d {sel,ov,ir,ol}", i), 32'(outs()),
            32'({vecs[i].sel, vecs[i].ov, vecs[i].ir, vecs[i].ol}));
      @(posedge clk); #1;
    end

    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b0;
    model_step(1'b1, 2'b00, 2'b00, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] exp;
      rst       = ($urandom_range(99) == 0);
      in_valid  = ($urandom_range(3) == 0) ? 2'b00 : 2'($urandom_range(3));
      in_last   = {($urandom_range(2) == 0), ($urandom_range(2) == 0)};
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      exp = model_out(rst, in_valid, in_last, out_ready);
      check("random {sel,ov,ir,ol}", 32'(outs()), 32'(exp));
      @(posedge clk);
      model_step(rst, in_valid, in_last, out_ready);
      #1;
    end

`ifdef MUX2_RR_STATS_EN
    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("stats reset beats0", 32'(beats0), 32'd0);
    check("stats reset beats1", 32'(beats1), 32'd0);
    pkt(0, 5);
    pkt(1, 3);
    check("beats0 after 5", 32'(beats0), 32'd5);
    check("beats1 after 3", 32'(beats1), 32'd3);
    in_valid = 2'b01; in_last = 2'b00;
    @(posedge clk); #1;
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    check("clr beats0", 32'(beats0), 32'd0);
    check("clr beats1", 32'(beats1), 32'd0);
    for (int b = 0; b < 16; b++) begin
      in_last = (b == 15) ? 2'b01 : 2'b00;
      @(posedge clk); #1;
      if (b == 14) check("beats0 at 15", 32'(beats0), 32'd15);
    end
    in_valid = '0; in_last = '0;
    check("beats0 wrap", 32'(beats0), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
